data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed 32-bit data memory that answers one read or write request
// at a time after a fixed LATENCY, with a busy flag and an illegal-request pulse.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [31:0]         mem_array [DEPTH];
    logic [ADDR_W-1:0]   req_idx;
    logic [ADDR_W-1:0]   commit_idx;
    logic [31:0]         commit_data;
    logic                commit_write;
    logic                commit;
    logic                mem_we;
    logic                unused_addr_bits;

    assign req_idx          = mem_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        commit       = 1'b0;
        commit_idx   = addr_q;
        commit_data  = wdata_q;
        commit_write = write_q;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read ^ mem_write) begin
                    addr_d  = req_idx;
                    write_d = mem_write;
                    if (mem_write) begin
                        wdata_d = mem_wdata;
                    end
                    // With a single-cycle latency the accept edge is also the commit edge.
                    if (LATENCY == 1) begin
                        state_d      = RESP;
                        commit       = 1'b1;
                        commit_idx   = req_idx;
                        commit_write = mem_write;
                        commit_data  = mem_wdata;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LOAD_CNT;
                    end
                end else if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            if (commit_write) begin
                mem_we = rst_n;
            end else begin
                rdata_d = mem_array[commit_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; only an in-flight commit is suppressed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[commit_idx] <= commit_data;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule
